// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and fetch constants.
package ysyx_23060187_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/ysyx_23060187_ifu_pcgen.sv
// Fetch PC generator: owns the fetch PC, the pending redirect target and the
// kill flag that marks the outstanding fetch as stale.
module ysyx_23060187_ifu_pcgen
    import ysyx_23060187_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_boot,
    input  logic            in_req,
    input  logic            in_wait,
    input  logic            in_hold,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            rsp_valid,
    input  logic            inst_fire,
    output logic [XLEN-1:0] fetch_pc,
    output logic            rsp_drop
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] redirect_aligned;
    logic [1:0]      unused_redirect_lsb;

    // Fetches are always word aligned; the low target bits carry no meaning.
    assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = redirect_pc[1:0];
    assign fetch_pc            = fetch_pc_q;

    // Next fetch PC selection: redirect always wins over the sequential step.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        kill_d     = kill_q;
        rsp_drop   = 1'b0;
        if (in_boot) begin
            if (redirect_valid) begin
                fetch_pc_d = redirect_aligned;
            end
        end else if (in_req) begin
            // The pending request must stay unchanged, so only remember the target.
            if (redirect_valid) begin
                target_d = redirect_aligned;
                kill_d   = 1'b1;
            end
        end else if (in_wait) begin
            if (rsp_valid && (kill_q || redirect_valid)) begin
                rsp_drop   = 1'b1;
                kill_d     = 1'b0;
                fetch_pc_d = redirect_valid ? redirect_aligned : target_q;
            end else if (redirect_valid) begin
                target_d = redirect_aligned;
                kill_d   = 1'b1;
            end
        end else if (in_hold) begin
            if (redirect_valid) begin
                fetch_pc_d = redirect_aligned;
            end else if (inst_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end
        end
    end

    // PC, target and kill state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            kill_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            kill_q     <= kill_d;
        end
    end

endmodule

// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit top: fetch FSM, memory request channel and the
// registered instruction buffer presented to decode.
module ysyx_23060187_ifu
    import ysyx_23060187_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err
);

    fetch_state_e    state_q, state_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_err_q, inst_err_d;
    logic [XLEN-1:0] fetch_pc;
    logic            rsp_drop;
    logic            inst_fire;

    assign inst_fire = inst_valid_q && inst_ready;

    ysyx_23060187_ifu_pcgen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pcgen (
        .clk            (clk),
        .rst            (rst),
        .in_boot        (state_q == BOOT),
        .in_req         (state_q == REQ),
        .in_wait        (state_q == WAIT),
        .in_hold        (state_q == HOLD),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rsp_valid      (imem_rsp_valid),
        .inst_fire      (inst_fire),
        .fetch_pc       (fetch_pc),
        .rsp_drop       (rsp_drop)
    );

    // Next-state and instruction-buffer capture; valids derive from the next state.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (rsp_drop) begin
                        state_d = REQ;
                    end else begin
                        inst_d     = imem_rsp_data;
                        inst_pc_d  = fetch_pc;
                        inst_err_d = imem_rsp_err;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
        req_valid_d  = (state_d == REQ);
        inst_valid_d = (state_d == HOLD);
    end

    // Fetch FSM with registered handshake outputs and instruction buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= INST_NOP;
            inst_pc_q    <= RESET_PC;
            inst_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_err_q   <= inst_err_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_err       = inst_err_q;

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Bench for the fetch unit: directed scenarios followed by random traffic,
// checked against an architectural next-PC model and a one-deep memory model.
module tb_ysyx_23060187_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;

    int          n_cmp;
    int          n_bad;
    int          n_acc;
    int          n_cons;
    logic [31:0] exp_pc;
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_dly;
    bit          prev_hold;
    logic [31:0] prev_addr;

    ysyx_23060187_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed word at the reset PC, an address hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0293;
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == 32'hFFFF_FFFC) || (a[6:2] == 5'd7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the models, then check after the edge.
    task automatic step(input bit rdy, input bit irdy, input bit redir,
                        input logic [31:0] rpc, input int dly);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if (mem_busy && !rst) begin
            if (mem_dly == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                imem_rsp_err   = mem_err(mem_addr);
                mem_busy       = 1'b0;
            end else begin
                mem_dly--;
            end
        end
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        prev_hold      = imem_req_valid && !rdy;
        prev_addr      = imem_req_addr;
        if (rst) begin
            mem_busy = 1'b0;
            exp_pc   = RST_PC;
        end else begin
            if (imem_req_valid && rdy) begin
                mem_busy = 1'b1;
                mem_addr = imem_req_addr;
                mem_dly  = dly;
                n_acc++;
            end
            if (inst_valid && irdy) n_cons++;
            if (redir) exp_pc = {rpc[31:2], 2'b00};
            else if (inst_valid && irdy) exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
        if (!rst) begin
            if (inst_valid) begin
                chk("model_inst_pc", inst_pc, exp_pc);
                chk("model_inst", inst, mem_word(exp_pc));
                chk("model_inst_err", 32'(inst_err), 32'(mem_err(exp_pc)));
            end
            if (prev_hold) begin
                chk("req_held_valid", 32'(imem_req_valid), 32'd1);
                chk("req_held_addr", imem_req_addr, prev_addr);
            end
            if (mem_busy) chk("one_outstanding", 32'(imem_req_valid), 32'd0);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"}, inst, NOP);
        chk({tag, "_inst_pc"}, inst_pc, RST_PC);
        chk({tag, "_inst_err"}, 32'(inst_err), 32'd0);
    endtask

    initial begin
        int cons_before;
        bit r_rdy;
        bit r_irdy;
        bit r_red;
        logic [31:0] r_pc;
        n_cmp = 0; n_bad = 0; n_acc = 0; n_cons = 0;
        exp_pc = RST_PC; mem_busy = 1'b0; mem_addr = 32'h0; mem_dly = 0;
        prev_hold = 1'b0; prev_addr = 32'h0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        chk_reset_values("rst");

        // First request, then memory stalls for 5 cycles.
        rst = 1'b0;
        step(0, 0, 0, 32'h0, 0);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 32'h0, 0);
            chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_req_addr", imem_req_addr, 32'h8000_0000);
        end
        step(1, 0, 0, 32'h0, 0);
        chk("accept_once", 32'(n_acc), 32'd1);
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        chk("wait_inst_valid", 32'(inst_valid), 32'd0);
        step(1, 0, 0, 32'h0, 0);
        chk("first_inst_valid", 32'(inst_valid), 32'd1);
        chk("first_inst", inst, 32'h0000_0293);
        chk("first_inst_pc", inst_pc, 32'h8000_0000);

        // Decode back-pressure in HOLD.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 32'h0, 0);
            chk("hold_inst_valid", 32'(inst_valid), 32'd1);
            chk("hold_inst", inst, 32'h0000_0293);
            chk("hold_inst_pc", inst_pc, 32'h8000_0000);
            chk("hold_no_req", 32'(imem_req_valid), 32'd0);
        end
        chk("hold_accepts", 32'(n_acc), 32'd1);
        step(1, 1, 0, 32'h0, 0);
        chk("seq_req_valid", 32'(imem_req_valid), 32'd1);
        chk("seq_req_addr", imem_req_addr, 32'h8000_0004);
        chk("seq_inst_valid", 32'(inst_valid), 32'd0);

        // Redirect while waiting for a slow response.
        step(1, 0, 0, 32'h0, 2);
        step(1, 0, 1, 32'h8000_1002, 0);
        chk("redir_wait_iv0", 32'(inst_valid), 32'd0);
        step(0, 0, 0, 32'h0, 0);
        chk("redir_wait_iv1", 32'(inst_valid), 32'd0);
        step(0, 0, 0, 32'h0, 0);
        chk("redir_drop_iv", 32'(inst_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr", imem_req_addr, 32'h8000_1000);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        chk("redir_inst_valid", 32'(inst_valid), 32'd1);
        chk("redir_inst_pc", inst_pc, 32'h8000_1000);

        // Redirect and handshake in the same HOLD cycle.
        cons_before = n_cons;
        step(0, 1, 1, 32'h8000_0100, 0);
        chk("both_consumed", 32'(n_cons - cons_before), 32'd1);
        chk("both_inst_valid", 32'(inst_valid), 32'd0);
        chk("both_req_addr", imem_req_addr, 32'h8000_0100);
        chk("both_req_valid", 32'(imem_req_valid), 32'd1);

        // Redirect in REQ to the top of the address space, with an access fault.
        step(1, 0, 1, 32'hFFFF_FFFC, 0);
        chk("req_redir_wait", 32'(imem_req_valid), 32'd0);
        step(0, 0, 0, 32'h0, 0);
        chk("req_redir_iv", 32'(inst_valid), 32'd0);
        chk("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        chk("err_inst_valid", 32'(inst_valid), 32'd1);
        chk("err_inst_err", 32'(inst_err), 32'd1);
        chk("err_inst_pc", inst_pc, 32'hFFFF_FFFC);
        step(0, 1, 0, 32'h0, 0);
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);

        // Reset while a fetch is outstanding.
        step(1, 0, 0, 32'h0, 0);
        chk("pre_rst_wait", 32'(imem_req_valid), 32'd0);
        rst = 1'b1;
        step(0, 0, 0, 32'h0, 0);
        chk_reset_values("midrst");
        rst = 1'b0;

        // Random traffic against the architectural model.
        cons_before = n_cons;
        for (int i = 0; i < 3000; i++) begin
            r_rdy  = ($urandom_range(0, 9) < 7);
            r_irdy = ($urandom_range(0, 9) < 6);
            r_red  = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       r_pc = $urandom();
                1:       r_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: r_pc = 32'h8000_0000 + 32'($urandom_range(0, 255));
            endcase
            step(r_rdy, r_irdy, r_red, r_pc, int'($urandom_range(0, 3)));
        end
        chk("random_progress", 32'((n_cons - cons_before) > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060187_ifu.md
Name: ysyx_23060187_ifu

Overview:
- Instruction fetch unit: the supplier side of the core's instruction/PC interface.
- Owns the fetch PC and issues one request at a time to instruction memory over a valid/ready request channel; receives the response on a valid-only channel.
- Presents {inst, inst_pc} to decode with a valid/ready handshake.
- Accepts redirects (jump/branch target) from execute and discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset
- XLEN, 32, address and instruction width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  execute requests fetch from redirect_pc
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and forced to 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address, word aligned
- imem_rsp_valid  in  1  response valid; single-cycle pulse, earliest one cycle after acceptance
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  XLEN  address of inst
- inst_err  out  1  access fault flag travelling with inst

Behaviour:
- Reset values: state=BOOT, fetch_pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, inst_err=0, kill=0.
- Outstanding requests: at most one at any time.
- Fetch PC update: sequential next PC is fetch_pc+4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
- BOOT: one cycle, then REQ.
- REQ:
  - Drive imem_req_valid=1, imem_req_addr=fetch_pc. Address stays stable until accepted.
  - valid&&ready -> WAIT.
  - A redirect in REQ does not retract or alter the pending request. Latch redirect_pc into fetch_pc target, set kill=1, and on acceptance go to WAIT.
- WAIT:
  - Response with kill=0: capture data/err into inst/inst_err, inst_pc=fetch_pc -> HOLD.
  - Response with kill=1: drop it, clear kill, fetch_pc=latched target -> REQ.
  - Redirect in WAIT: set kill=1 and latch target. If the redirect coincides with a response, that response is dropped.
- HOLD:
  - inst_valid=1. inst, inst_pc and inst_err stay stable until the handshake completes.
  - inst_valid&&inst_ready: fetch_pc = fetch_pc+4 -> REQ.
  - Redirect without handshake: inst_valid drops next cycle, fetch_pc=redirect_pc -> REQ.
  - Redirect and handshake in the same cycle: the transfer completes, and fetch_pc=redirect_pc (redirect overrides +4) -> REQ.
- Priority: redirect over sequential increment in every state. A newer redirect overwrites an older latched target.
- Latency and throughput: with zero-wait memory (ready=1, rsp one cycle later), request in cycle n, rsp in n+1, inst_valid in n+2. Throughput is one instruction per 3 cycles when inst_ready is held at 1.
- inst_err: no special flow. It is delivered like a normal instruction; the core raises the exception.
- Reset mid-operation: return to BOOT immediately. The memory shares rst, so no response for a pre-reset request arrives after reset.
- Outputs are registered. imem_req_valid and inst_valid have no combinational path from any input.

Decomposition:
- Package ysyx_23060187_pkg:
  - fetch FSM state enum (BOOT, REQ, WAIT, HOLD)
  - RESET_PC default
  - INST_NOP = 32'h0000_0013
  - PC_STEP = 4
- Sub-module ysyx_23060187_ifu_pcgen: fetch_pc register, +4 / redirect selection, target latch and kill flag. The FSM and output buffer stay in the top of this block.

Test Plan:
- Reset then zero-wait memory returning 0x00000293 at 0x80000000 -> first request addr 0x80000000 in cycle 1 after reset release; inst_valid=1, inst=0x00000293, inst_pc=0x80000000 two cycles after acceptance; next request addr 0x80000004.
- imem_req_ready low 5 cycles -> imem_req_valid held 1 and imem_req_addr stable at 0x80000000 all 5 cycles; exactly one acceptance.
- inst_ready low 4 cycles in HOLD -> inst/inst_pc stable, no new request issued; on ready high the next request goes to 0x80000004.
- Redirect to 0x80001002 while in WAIT -> the response for 0x80000004 is never presented; next request addr 0x80001000; the delivered inst_pc is 0x80001000.
- Redirect and handshake in the same cycle in HOLD (target 0x80000100) -> the instruction is counted as consumed once; next request addr 0x80000100, not +4.
- Fetch at 0xFFFFFFFC with imem_rsp_err=1 -> inst_err=1 delivered with inst_pc=0xFFFFFFFC; next request addr 0x00000000. Asserting rst during WAIT -> all outputs at reset values next cycle.
